// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mem_bus_arbiter                                                 |
// | Shares one byte-wide external memory bus between the instruction-fetch   |
// | cache controller (port 0) and the load/store cache controller (port 1).  |
// | A grant covers a whole 1/2/4-byte burst sized by the LIM code, ties are  |
// | resolved round-robin, and a watchdog aborts bursts whose memory stalls.  |
// |                                                                          |
// | Ports                                                                    |
// |   clk_i, rst_ni          clock, asynchronous active-low reset            |
// |   reqN_i, weN_i, limN_i  per-port request, direction, burst size code    |
// |   addrN_i, wdN_i         per-port current byte address and write byte    |
// |   mrdy_i                 memory beat-complete strobe                     |
// |   md_io                  memory data, driven only during a granted write |
// |   maddr_o, mwe_o         memory address and write enable                 |
// |   gntN_o                 registered grant, one-hot or zero               |
// |   rdyN_o                 per-port beat strobe (mrdy_i & gntN_o)          |
// |   rd_o                   read byte (follows md_io)                       |
// |   errN_o                 one-cycle pulse when the watchdog aborts        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [2:0]  lim0_i,
  input  logic [2:0]  lim1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [7:0]  wd0_i,
  input  logic [7:0]  wd1_i,
  input  logic        mrdy_i,
  inout  wire  [7:0]  md_io,
  output logic [31:0] maddr_o,
  output logic        mwe_o,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        rdy0_o,
  output logic        rdy1_o,
  output logic [7:0]  rd_o,
  output logic        err0_o,
  output logic        err1_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Watchdog fires on the TIMEOUT-th consecutive stall cycle, i.e. when the
  // counter already holds TIMEOUT-1 earlier stalls and MRDY is low again.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        owner_q;
  logic        last_q;
  logic [2:0]  beats_q;
  logic [2:0]  need_q;
  logic [15:0] wdog_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        err0_q;
  logic        err1_q;

  logic [2:0]  beats_d;
  logic [15:0] wdog_d;
  logic        busy;
  logic        own_req;
  logic        own_we;
  logic [31:0] own_addr;
  logic [7:0]  own_wd;
  logic        pick1;
  logic [2:0]  lim_sel;
  logic [2:0]  need_sel;
  logic        burst_done;
  logic        stall_out;

  always_comb begin
    busy     = (state_q == ST_BUSY);
    own_req  = owner_q ? req1_i  : req0_i;
    own_we   = owner_q ? we1_i   : we0_i;
    own_addr = owner_q ? addr1_i : addr0_i;
    own_wd   = owner_q ? wd1_i   : wd0_i;

    // Port 1 wins when alone, or on a tie when port 0 owned the last burst.
    pick1    = req1_i & (~req0_i | ~last_q);
    lim_sel  = pick1 ? lim1_i : lim0_i;
    if (lim_sel == 3'd0) begin
      need_sel = 3'd1;
    end else if (lim_sel == 3'd1) begin
      need_sel = 3'd2;
    end else begin
      need_sel = 3'd4;
    end

    beats_d    = beats_q + {2'b00, mrdy_i};
    wdog_d     = mrdy_i ? 16'd0 : (wdog_q + 16'd1);
    burst_done = mrdy_i && (beats_d == need_q);
    stall_out  = !mrdy_i && (wdog_q == WDOG_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      beats_q <= 3'd0;
      need_q  <= 3'd1;
      wdog_q  <= 16'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req0_i || req1_i) begin
            owner_q <= pick1;
            gnt0_q  <= ~pick1;
            gnt1_q  <= pick1;
            beats_q <= 3'd0;
            wdog_q  <= 16'd0;
            need_q  <= need_sel;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          beats_q <= beats_d;
          wdog_q  <= wdog_d;
          // Completion outranks a dropped request, which outranks a stall.
          if (burst_done) begin
            state_q <= ST_RELEASE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            last_q  <= owner_q;
          end else if (!own_req) begin
            state_q <= ST_RELEASE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
          end else if (stall_out) begin
            state_q <= ST_RELEASE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            err0_q  <= ~owner_q;
            err1_q  <= owner_q;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus outputs decode straight from the registered state so that an async
  // reset parks the bus immediately, without waiting for a clock edge.
  always_comb begin
    maddr_o = busy ? own_addr : 32'd0;
    mwe_o   = busy & own_we;
    rdy0_o  = mrdy_i & gnt0_q;
    rdy1_o  = mrdy_i & gnt1_q;
    rd_o    = md_io;
    gnt0_o  = gnt0_q;
    gnt1_o  = gnt1_q;
    err0_o  = err0_q;
    err1_o  = err1_q;
  end

  assign md_io = mwe_o ? own_wd : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_mem_bus_arbiter                                              |
// | Bench for mem_bus_arbiter: directed scenarios followed by randomized     |
// | bursts, checked against a transaction-level model of grants, beats and   |
// | bus contents.                                                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [2:0]  lim [2];
  logic [31:0] addr [2];
  logic [7:0]  wd [2];
  logic        mrdy = 1'b0;
  logic        mem_oe = 1'b0;
  logic [7:0]  mem_dq = 8'h00;
  wire  [7:0]  md;
  logic [31:0] maddr;
  logic        mwe;
  logic [1:0]  gnt;
  logic [1:0]  rdy;
  logic [1:0]  err;
  logic [7:0]  rd;

  int total = 0;
  int bad = 0;
  int last_done = 1;
  logic [7:0] rdq [$];
  logic [7:0] wdq [$];

  assign md = mem_oe ? mem_dq : 8'hzz;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req[0]), .req1_i(req[1]),
    .we0_i(we[0]), .we1_i(we[1]),
    .lim0_i(lim[0]), .lim1_i(lim[1]),
    .addr0_i(addr[0]), .addr1_i(addr[1]),
    .wd0_i(wd[0]), .wd1_i(wd[1]),
    .mrdy_i(mrdy), .md_io(md),
    .maddr_o(maddr), .mwe_o(mwe),
    .gnt0_o(gnt[0]), .gnt1_o(gnt[1]),
    .rdy0_o(rdy[0]), .rdy1_o(rdy[1]),
    .rd_o(rd),
    .err0_o(err[0]), .err1_o(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int need_of(input logic [2:0] l);
    return (l == 3'd0) ? 1 : ((l == 3'd1) ? 2 : 4);
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the port that did not
  // complete the previous burst wins.
  function automatic int winner();
    if (req == 2'b11) return (last_done == 1) ? 0 : 1;
    return req[1] ? 1 : 0;
  endfunction

  // Entered at +1 of an IDLE cycle with requests set; returns at +1 of the
  // IDLE cycle that follows the RELEASE cycle.
  task automatic serve(input int p, input int gap, input int drop_after, input bit keep_req);
    int q;
    int need;
    int nb;
    int cyc;
    q = 1 - p;
    need = need_of(lim[p]);
    nb = 0;
    cyc = 0;
    step();
    chk("gnt_own", gnt[p], 1'b1);
    chk("gnt_other", gnt[q], 1'b0);
    chk("maddr_grant", maddr, addr[p]);
    chk("mwe_grant", mwe, we[p]);
    while (nb < need && cyc < 64) begin
      mrdy = ((cyc + 1) % gap) == 0;
      if (drop_after >= 0 && nb == drop_after) begin
        mrdy = 1'b0;
        req[p] = 1'b0;
      end
      mem_oe = mrdy & ~we[p];
      if (mrdy && !we[p]) mem_dq = (rdq.size() > 0) ? rdq.pop_front() : 8'($urandom);
      #1;
      chk("rdy_own", rdy[p], mrdy);
      chk("rdy_other", rdy[q], 1'b0);
      chk("maddr_busy", maddr, addr[p]);
      chk("mwe_busy", mwe, we[p]);
      chk("err_busy", err, 2'b00);
      if (mrdy && !we[p]) chk("rd_data", rd, mem_dq);
      if (mrdy && we[p]) chk("md_write", md, wd[p]);
      if (!req[p]) break;
      step();
      if (mrdy) begin
        nb++;
        addr[p] = addr[p] + 32'd1;
        wd[p] = (wdq.size() > 0) ? wdq.pop_front() : 8'($urandom);
      end
      mrdy = 1'b0;
      mem_oe = 1'b0;
      cyc++;
    end
    if (!req[p]) step();
    if (cyc >= 64) chk("burst_bound", cyc, 0);
    mrdy = 1'b0;
    mem_oe = 1'b0;
    if (!keep_req) req[p] = 1'b0;
    if (nb == need) last_done = p;
    #1;
    chk("rel_gnt", gnt, 2'b00);
    chk("rel_mwe", mwe, 1'b0);
    chk("rel_maddr", maddr, 32'd0);
    chk("rel_err", err, 2'b00);
    step();
    chk("idle_gnt", gnt, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int p;
    int gap;
    int drop;
    int guard;
    lim[0] = 3'd0; lim[1] = 3'd0;
    addr[0] = 32'd0; addr[1] = 32'd0;
    wd[0] = 8'd0; wd[1] = 8'd0;

    // Reset state
    step();
    step();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_err", err, 2'b00);
    chk("rst_mwe", mwe, 1'b0);
    chk("rst_maddr", maddr, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_gnt0", gnt, 2'b00);

    // Single 4-byte read on port 0, MRDY every second cycle
    req[0] = 1'b1; we[0] = 1'b0; lim[0] = 3'd2; addr[0] = 32'h100;
    rdq = '{8'h11, 8'h22, 8'h33, 8'h44};
    serve(winner(), 2, -1, 1'b0);
    chk("read_beats_left", rdq.size(), 0);
    chk("read_addr_end", addr[0], 32'h104);

    // Two-byte write on port 1
    req[1] = 1'b1; we[1] = 1'b1; lim[1] = 3'd1; addr[1] = 32'h2000; wd[1] = 8'hAB;
    wdq = '{8'hCD};
    serve(winner(), 1, -1, 1'b0);
    chk("write_beats_left", wdq.size(), 0);

    // Tie with both requests held: strict alternation
    req = 2'b11; we = 2'b00; lim[0] = 3'd0; lim[1] = 3'd0;
    chk("tie_first_winner", winner(), 0);
    serve(winner(), 1, -1, 1'b1);
    serve(winner(), 1, -1, 1'b1);
    serve(winner(), 1, -1, 1'b1);
    serve(winner(), 1, -1, 1'b0);

    // Abort: port 0 drops after one beat, pending port 1 follows
    req = 2'b11; lim[0] = 3'd2; lim[1] = 3'd0; addr[0] = 32'h300;
    serve(winner(), 1, 1, 1'b0);
    serve(winner(), 1, -1, 1'b0);

    // Watchdog on port 1
    req[1] = 1'b1; we[1] = 1'b0; lim[1] = 3'd2;
    step();
    chk("wd_gnt", gnt, 2'b10);
    for (int k = 0; k < TMO - 1; k++) begin
      step();
      chk("wd_hold_gnt", gnt, 2'b10);
      chk("wd_no_err", err, 2'b00);
    end
    step();
    chk("wd_err", err, 2'b10);
    chk("wd_gnt_fall", gnt, 2'b00);
    chk("wd_mwe", mwe, 1'b0);
    req[1] = 1'b0;
    step();
    chk("wd_err_pulse", err, 2'b00);
    chk("wd_idle_gnt", gnt, 2'b00);

    // Async reset in the middle of a write burst
    req[1] = 1'b1; we[1] = 1'b1; lim[1] = 3'd2; addr[1] = 32'h4000; wd[1] = 8'h5C;
    step();
    chk("ar_gnt", gnt, 2'b10);
    mrdy = 1'b1;
    step();
    mrdy = 1'b0;
    addr[1] = addr[1] + 32'd1;
    #1;
    chk("ar_mwe_before", mwe, 1'b1);
    rst_n = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; lim[0] = 3'd0;
    #1;
    chk("ar_gnt_async", gnt, 2'b00);
    chk("ar_mwe_async", mwe, 1'b0);
    chk("ar_maddr_async", maddr, 32'd0);
    chk("ar_err_async", err, 2'b00);
    #2;
    rst_n = 1'b1;
    last_done = 1;
    serve(winner(), 1, -1, 1'b0);
    we[1] = 1'b0;
    serve(winner(), 1, -1, 1'b0);

    // Randomized bursts
    for (int it = 0; it < 40; it++) begin
      mrdy = 1'($urandom);
      #1;
      chk("idle_rdy", rdy, 2'b00);
      chk("idle_maddr", maddr, 32'd0);
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom);
        lim[k] = 3'($urandom_range(0, 7));
        addr[k] = $urandom;
        wd[k] = 8'($urandom);
      end
      req = 2'($urandom_range(1, 3));
      guard = 0;
      while (req != 2'b00 && guard < 4) begin
        p = winner();
        gap = $urandom_range(1, 3);
        drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, need_of(lim[p]) - 1) : -1;
        serve(p, gap, drop, 1'b0);
        guard++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
